apb_slave_regfile: RTL and testbench

- Synthesizable APB completer sitting directly downstream of the APB driver BFM.
- Consumes PSELx[n]/PENABLE/PADDR/PWDATA/PSTRB/PPROT and returns PREADY/PRDATA/PSLVERR.
- Holds a bank of word-aligned R/W registers, with configurable wait states and protection/range error signalling.
- Serves as the DUT-side target for agent bring-up and protocol regression.

---
 rtl/apb_agent_pkg.sv | 24 ++
 rtl/apb_parity_gen_chk.sv | 28 ++
 rtl/apb_slave_regfile.sv | 210 +++++++++++++++++++++
 tb/tb_apb_slave_regfile.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_agent_pkg.sv
// Shared APB agent types: completer FSM states, error causes and odd-parity helper.
package apb_agent_pkg;

    localparam logic PREADY_READY = 1'b1;
    localparam logic PWRITE_WRITE = 1'b1;

    typedef enum logic {
        IDLE,
        ACCESS
    } apb_slave_state_e;

    typedef enum logic [2:0] {
        ERR_NONE,
        ERR_RANGE,
        ERR_ALIGN,
        ERR_PRIV,
        ERR_PARITY
    } apb_slave_err_e;

    function automatic logic odd_parity8(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/apb_parity_gen_chk.sv
// Byte-wise odd parity generator and comparator; partial top byte is zero-padded.
module apb_parity_gen_chk
    import apb_agent_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]         data,
    input  logic [(WIDTH+7)/8-1:0]   chk_in,
    output logic [(WIDTH+7)/8-1:0]   chk_gen,
    output logic                     err
);

    localparam int NB = (WIDTH + 7) / 8;

    logic [NB*8-1:0] padded;

    assign padded = (NB*8)'(data);

    always_comb begin
        chk_gen = '0;
        for (int i = 0; i < NB; i++) begin
            chk_gen[i] = odd_parity8(padded[8*i +: 8]);
        end
    end

    assign err = |(chk_gen ^ chk_in);

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with a word-aligned register bank, fixed wait states and error decode.
// Optional interface parity checking is enabled by defining APB_SLAVE_PARITY_CHK_EN.
module apb_slave_regfile
    import apb_agent_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]   PRIV_MASK   = 'h0001,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic                         PWRITE,
    input  logic [ADDR_WIDTH-1:0]        PADDR,
    input  logic [2:0]                   PPROT,
    input  logic [DATA_WIDTH-1:0]        PWDATA,
    input  logic [DATA_WIDTH/8-1:0]      PSTRB,
    output logic                         PREADY,
    output logic [DATA_WIDTH-1:0]        PRDATA,
    output logic                         PSLVERR,
    input  logic [(ADDR_WIDTH+7)/8-1:0]  PADDRCHK,
    input  logic                         PCTRLCHK,
    input  logic [DATA_WIDTH/8-1:0]      PWDATACHK,
    output logic                         PREADYCHK,
    output logic [DATA_WIDTH/8-1:0]      PRDATACHK,
    output logic                         PSLVERRCHK,
    output logic                         dbg_state
);

    localparam int                  NBYTES     = DATA_WIDTH / 8;
    localparam int                  OFF_W      = $clog2(NBYTES);
    localparam int                  IDX_W      = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH+1)'(NUM_REGS * NBYTES);
    localparam logic [3:0]          WS         = 4'(WAIT_STATES);

    apb_slave_state_e       state_q, state_d;
    apb_slave_err_e         err_q, err_d, setup_err;
    logic [3:0]             wait_q, wait_d;
    logic [IDX_W-1:0]       idx_q, idx_d, setup_idx;
    logic                   write_q, write_d;
    logic                   pready_q, pready_d;
    logic                   pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]  prdata_q, prdata_d;
    logic                   preadychk_q, preadychk_d;
    logic                   pslverrchk_q, pslverrchk_d;
    logic [NBYTES-1:0]      prdatachk_q, prdatachk_d;
    logic                   commit;
    logic                   par_err;
    logic [DATA_WIDTH-1:0]  regs [NUM_REGS];

    assign setup_idx = PADDR[OFF_W +: IDX_W];

`ifdef APB_SLAVE_PARITY_CHK_EN
    logic [(ADDR_WIDTH+7)/8-1:0] unused_addr_gen;
    logic                        unused_ctrl_gen;
    logic [NBYTES-1:0]           unused_wdata_gen;
    logic                        unused_rd_err;
    logic                        addr_par_err, ctrl_par_err, wdata_par_err;

    apb_parity_gen_chk #(.WIDTH(ADDR_WIDTH)) u_addr_par (
        .data(PADDR), .chk_in(PADDRCHK), .chk_gen(unused_addr_gen), .err(addr_par_err)
    );
    apb_parity_gen_chk #(.WIDTH(4)) u_ctrl_par (
        .data({PPROT, PWRITE}), .chk_in(PCTRLCHK), .chk_gen(unused_ctrl_gen), .err(ctrl_par_err)
    );
    apb_parity_gen_chk #(.WIDTH(DATA_WIDTH)) u_wdata_par (
        .data(PWDATA), .chk_in(PWDATACHK), .chk_gen(unused_wdata_gen), .err(wdata_par_err)
    );
    apb_parity_gen_chk #(.WIDTH(DATA_WIDTH)) u_rdata_par (
        .data(prdata_d), .chk_in('0), .chk_gen(prdatachk_d), .err(unused_rd_err)
    );

    assign par_err      = addr_par_err | ctrl_par_err | ((PWRITE == PWRITE_WRITE) & wdata_par_err);
    assign preadychk_d  = ~pready_d;
    assign pslverrchk_d = ~pslverr_d;
`else
    logic unused_chk;

    assign unused_chk   = ^{PADDRCHK, PCTRLCHK, PWDATACHK, PPROT[2:1]};
    assign par_err      = 1'b0;
    assign preadychk_d  = 1'b0;
    assign pslverrchk_d = 1'b0;
    assign prdatachk_d  = '0;
`endif

    // Highest-priority cause wins; the cause is kept for the whole access phase.
    always_comb begin
        setup_err = ERR_NONE;
        if (par_err)
            setup_err = ERR_PARITY;
        else if ({1'b0, PADDR} >= ADDR_LIMIT)
            setup_err = ERR_RANGE;
        else if ((PADDR & ADDR_WIDTH'(NBYTES - 1)) != '0)
            setup_err = ERR_ALIGN;
        else if ((PWRITE == PWRITE_WRITE) && PRIV_MASK[setup_idx] && !PPROT[0])
            setup_err = ERR_PRIV;
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        idx_d     = idx_q;
        write_d   = write_q;
        err_d     = err_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;
        commit    = 1'b0;
        case (state_q)
            IDLE: begin
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = '0;
                if (PSEL && !PENABLE) begin
                    state_d = ACCESS;
                    wait_d  = WS;
                    idx_d   = setup_idx;
                    write_d = (PWRITE == PWRITE_WRITE);
                    err_d   = setup_err;
                    if (WS == 4'd0) begin
                        pready_d  = PREADY_READY;
                        pslverr_d = (setup_err != ERR_NONE);
                        prdata_d  = (PWRITE != PWRITE_WRITE && setup_err == ERR_NONE) ?
                                    regs[setup_idx] : '0;
                    end
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_d   = IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                end else if (pready_q == PREADY_READY) begin
                    if (PENABLE) begin
                        state_d   = IDLE;
                        commit    = write_q && (err_q == ERR_NONE);
                        pready_d  = 1'b0;
                        pslverr_d = 1'b0;
                        prdata_d  = '0;
                    end
                end else if (wait_q <= 4'd1) begin
                    wait_d    = 4'd0;
                    pready_d  = PREADY_READY;
                    pslverr_d = (err_q != ERR_NONE);
                    prdata_d  = (!write_q && err_q == ERR_NONE) ? regs[idx_q] : '0;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q      <= IDLE;
            wait_q       <= '0;
            idx_q        <= '0;
            write_q      <= 1'b0;
            err_q        <= ERR_NONE;
            pready_q     <= 1'b0;
            pslverr_q    <= 1'b0;
            prdata_q     <= '0;
            preadychk_q  <= 1'b0;
            pslverrchk_q <= 1'b0;
            prdatachk_q  <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            idx_q        <= idx_d;
            write_q      <= write_d;
            err_q        <= err_d;
            pready_q     <= pready_d;
            pslverr_q    <= pslverr_d;
            prdata_q     <= prdata_d;
            preadychk_q  <= preadychk_d;
            pslverrchk_q <= pslverrchk_d;
            prdatachk_q  <= prdatachk_d;
        end
    end

    // Write data is taken from the completion cycle; APB holds PWDATA/PSTRB stable until then.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= RESET_VAL;
            end
        end else if (commit) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (PSTRB[b]) begin
                    regs[idx_q][8*b +: 8] <= PWDATA[8*b +: 8];
                end
            end
        end
    end

    assign PREADY     = pready_q;
    assign PSLVERR    = pslverr_q;
    assign PRDATA     = prdata_q;
    assign PREADYCHK  = preadychk_q;
    assign PSLVERRCHK = pslverrchk_q;
    assign PRDATACHK  = prdatachk_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench: drivers push expected responses, a negedge monitor pops and compares.
module tb_apb_slave_regfile;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int NB = DW / 8;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic          psel0, psel3, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [2:0]    PPROT;
    logic [DW-1:0] PWDATA;
    logic [NB-1:0] PSTRB;
    logic [1:0]    PADDRCHK;
    logic          PCTRLCHK;
    logic [NB-1:0] PWDATACHK;

    logic          pready0, pslverr0, preadychk0, pslverrchk0, dbg0;
    logic [DW-1:0] prdata0;
    logic [NB-1:0] prdatachk0;
    logic          pready3, pslverr3, preadychk3, pslverrchk3, dbg3;
    logic [DW-1:0] prdata3;
    logic [NB-1:0] prdatachk3;

    int n_vec = 0;
    int n_err = 0;

    // entry = {is_read, latency[3:0], slverr, rdata[31:0]}
    logic [37:0] exp_q[$];

    always #5 PCLK = ~PCLK;

    apb_slave_regfile #(.WAIT_STATES(0)) u_dut0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel0), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PPROT(PPROT), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PREADY(pready0), .PRDATA(prdata0), .PSLVERR(pslverr0),
        .PADDRCHK(PADDRCHK), .PCTRLCHK(PCTRLCHK), .PWDATACHK(PWDATACHK),
        .PREADYCHK(preadychk0), .PRDATACHK(prdatachk0), .PSLVERRCHK(pslverrchk0),
        .dbg_state(dbg0)
    );

    apb_slave_regfile #(.WAIT_STATES(3)) u_dut3 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel3), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PPROT(PPROT), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PREADY(pready3), .PRDATA(prdata3), .PSLVERR(pslverr3),
        .PADDRCHK(PADDRCHK), .PCTRLCHK(PCTRLCHK), .PWDATACHK(PWDATACHK),
        .PREADYCHK(preadychk3), .PRDATACHK(prdatachk3), .PSLVERRCHK(pslverrchk3),
        .dbg_state(dbg3)
    );

    logic          pready_m, pslverr_m, preadychk_m, pslverrchk_m;
    logic [DW-1:0] prdata_m;
    logic [NB-1:0] prdatachk_m;

    assign pready_m     = (psel0 & pready0) | (psel3 & pready3);
    assign pslverr_m    = psel3 ? pslverr3 : pslverr0;
    assign prdata_m     = psel3 ? prdata3 : prdata0;
    assign preadychk_m  = psel3 ? preadychk3 : preadychk0;
    assign pslverrchk_m = psel3 ? pslverrchk3 : pslverrchk0;
    assign prdatachk_m  = psel3 ? prdatachk3 : prdatachk0;

    function automatic logic [NB-1:0] par_bytes(input logic [DW-1:0] d);
        logic [NB-1:0] p;
        for (int i = 0; i < NB; i++) p[i] = ~^d[8*i +: 8];
        return p;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int          acc_cnt = 0;
    logic [37:0] e;

    always @(negedge PCLK) begin
        if (!PRESETn) begin
            acc_cnt = 0;
        end else if ((psel0 | psel3) && PENABLE) begin
            acc_cnt++;
            if (pready_m) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_pready at t=%0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("latency", DW'(acc_cnt), DW'(e[36:33]));
                    check("pslverr", DW'(pslverr_m), DW'(e[32]));
                    if (e[37]) check("prdata", prdata_m, e[31:0]);
`ifdef APB_SLAVE_PARITY_CHK_EN
                    check("preadychk", DW'(preadychk_m), '0);
                    check("pslverrchk", DW'(pslverrchk_m), DW'(~e[32]));
                    if (e[37]) check("prdatachk", DW'(prdatachk_m), DW'(par_bytes(e[31:0])));
`else
                    check("chk_outs", DW'({preadychk_m, pslverrchk_m, prdatachk_m}), '0);
`endif
                end
                acc_cnt = 0;
            end
        end else begin
            acc_cnt = 0;
        end
    end

    // ---------------- drivers ----------------
    task automatic drive_setup(input bit dut3, input logic wr, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data, input logic [NB-1:0] strb,
                               input logic [2:0] prot, input bit bad_wpar);
        psel0     = !dut3;
        psel3     = dut3;
        PENABLE   = 1'b0;
        PWRITE    = wr;
        PADDR     = addr;
        PWDATA    = data;
        PSTRB     = strb;
        PPROT     = prot;
        PADDRCHK  = {~^addr[15:8], ~^addr[7:0]};
        PCTRLCHK  = ~^{prot, wr};
        PWDATACHK = par_bytes(data) ^ {{(NB-1){1'b0}}, bad_wpar};
    endtask

    task automatic xfer(input bit dut3, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic [NB-1:0] strb, input logic [2:0] prot,
                        input logic exp_err, input logic [DW-1:0] exp_rd, input bit bad_wpar = 1'b0);
        bit got;
        exp_q.push_back({~wr, (dut3 ? 4'd4 : 4'd1), exp_err, exp_rd});
        @(posedge PCLK) #1;
        drive_setup(dut3, wr, addr, data, strb, prot, bad_wpar);
        @(posedge PCLK) #1;
        PENABLE = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge PCLK);
            if (pready_m) got = 1'b1;
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: addr 0x%04h got no PREADY, expected one within 20 cycles", addr);
            if (exp_q.size() > 0) void'(exp_q.pop_back());
        end
    endtask

    task automatic go_idle();
        @(posedge PCLK) #1;
        psel0   = 1'b0;
        psel3   = 1'b0;
        PENABLE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        psel0 = 0; psel3 = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PPROT = '0;
        PWDATA = '0; PSTRB = '0; PADDRCHK = '0; PCTRLCHK = 0; PWDATACHK = '0;
        repeat (3) @(posedge PCLK);
        #1;
        check("rst_outs0", DW'({pready0, pslverr0, preadychk0, pslverrchk0, prdatachk0, dbg0}), '0);
        check("rst_rdata0", prdata0, '0);
        check("rst_outs3", DW'({pready3, pslverr3, preadychk3, pslverrchk3, prdatachk3, dbg3}), '0);
        check("rst_rdata3", prdata3, '0);
        @(negedge PCLK);
        PRESETn = 1'b1;

        // zero-wait completer, back-to-back transfers
        xfer(0, 1, 16'h0004, 32'hDEADBEEF, 4'hF, 3'b000, 0, '0);
        xfer(0, 0, 16'h0004, '0,           4'hF, 3'b000, 0, 32'hDEADBEEF);
        xfer(0, 1, 16'h000C, 32'hAABBCCDD, 4'hF, 3'b000, 0, '0);
        xfer(0, 1, 16'h000C, 32'h11223344, 4'h5, 3'b000, 0, '0);
        xfer(0, 0, 16'h000C, '0,           4'h0, 3'b000, 0, 32'hAA22CC44);
        xfer(0, 1, 16'h0000, 32'h00000005, 4'hF, 3'b000, 1, '0);
        xfer(0, 0, 16'h0000, '0,           4'hF, 3'b000, 0, 32'h00000000);
        xfer(0, 1, 16'h0000, 32'h00000077, 4'hF, 3'b001, 0, '0);
        xfer(0, 0, 16'h0000, '0,           4'hF, 3'b000, 0, 32'h00000077);
        xfer(0, 0, 16'h0040, '0,           4'hF, 3'b000, 1, 32'h00000000);
        xfer(0, 0, 16'h0002, '0,           4'hF, 3'b000, 1, 32'h00000000);
        xfer(0, 1, 16'h003C, 32'h12345678, 4'hF, 3'b000, 0, '0);
        xfer(0, 1, 16'h003C, 32'hFFFFFFFF, 4'h0, 3'b000, 0, '0);
        xfer(0, 0, 16'h003C, '0,           4'hF, 3'b000, 0, 32'h12345678);
        xfer(0, 1, 16'h0040, 32'h0000FFFF, 4'hF, 3'b000, 1, '0);
        xfer(0, 1, 16'h0005, 32'h0000FFFF, 4'hF, 3'b000, 1, '0);
        xfer(0, 0, 16'h0004, '0,           4'hF, 3'b000, 0, 32'hDEADBEEF);
        go_idle();

        // three wait states
        xfer(1, 0, 16'h0008, '0,           4'hF, 3'b000, 0, 32'h00000000);
        xfer(1, 1, 16'h0018, 32'hCAFEF00D, 4'hF, 3'b000, 0, '0);
        xfer(1, 0, 16'h0018, '0,           4'hF, 3'b000, 0, 32'hCAFEF00D);
        xfer(1, 0, 16'h0044, '0,           4'hF, 3'b000, 1, 32'h00000000);
        xfer(1, 1, 16'h0000, 32'h00000009, 4'hF, 3'b000, 1, '0);
        go_idle();

        // abort after one access cycle: no completion, no write
        @(posedge PCLK) #1;
        drive_setup(1, 1, 16'h0014, 32'h5A5A5A5A, 4'hF, 3'b001, 0);
        @(posedge PCLK) #1;
        PENABLE = 1'b1;
        @(posedge PCLK) #1;
        psel3 = 1'b0;
        PENABLE = 1'b0;
        repeat (2) @(negedge PCLK);
        check("abort_pready", DW'(pready3), '0);
        check("abort_state", DW'(dbg3), '0);
        xfer(1, 0, 16'h0014, '0, 4'hF, 3'b000, 0, 32'h00000000);
        go_idle();

`ifdef APB_SLAVE_PARITY_CHK_EN
        xfer(0, 1, 16'h0014, 32'h00000001, 4'hF, 3'b000, 1, '0, 1'b1);
        xfer(0, 0, 16'h0014, '0, 4'hF, 3'b000, 0, 32'h00000000);
        xfer(0, 1, 16'h0014, 32'h00018003, 4'hF, 3'b000, 0, '0);
        xfer(0, 0, 16'h0014, '0, 4'hF, 3'b000, 0, 32'h00018003);
        go_idle();
`endif

        // reset in the middle of a waited write
        @(posedge PCLK) #1;
        drive_setup(1, 1, 16'h0010, 32'h99999999, 4'hF, 3'b000, 0);
        @(posedge PCLK) #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        #2;
        PRESETn = 1'b0;
        #1;
        check("midrst_outs", DW'({pready3, pslverr3, dbg3}), '0);
        check("midrst_rdata", prdata3, '0);
        @(posedge PCLK) #1;
        psel3 = 1'b0;
        PENABLE = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        xfer(1, 0, 16'h0010, '0, 4'hF, 3'b000, 0, 32'h00000000);
        xfer(1, 0, 16'h0018, '0, 4'hF, 3'b000, 0, 32'h00000000);
        go_idle();
        xfer(0, 0, 16'h0004, '0, 4'hF, 3'b000, 0, 32'h00000000);
        go_idle();

        repeat (3) @(posedge PCLK);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover_expected: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
